serial_signed_comparator: RTL and testbench
===========================================

SERIAL_SIGNED_COMPARATOR -- requirements
Module: serial_signed_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be a multiple of 4 and >= 8.
REQ-002 Parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-003 clk_ip  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n_ip  input  1: reset, asynchronous and active-low.
REQ-005 in_valid_ip  input  1: operand pair presented.
REQ-006 in_ready_op  output  1: block can accept an operand pair.
REQ-007 a_ip  input  WIDTH: operand A.
REQ-008 b_ip  input  WIDTH: operand B.
REQ-009 out_valid_op  output  1: result flags valid.
REQ-010 out_ready_ip  input  1: consumer accepts the result.
REQ-011 a_op_G  output  1: A > B.
REQ-012 a_op_E_b  output  1: A == B.
REQ-013 b_op_G  output  1: B > A.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready_op SHALL be 1 only in IDLE.
REQ-015 IDLE: on in_valid_ip & in_ready_op, capture a_ip/b_ip into shift registers, clear nibble counter to 0, preset result to equal (G=0, E=1, G=0), go BUSY.
REQ-016 BUSY: each cycle compare the most-significant unprocessed nibble pair, shift both registers left by 4, increment counter.
REQ-017 Compare order: MS nibble first; with SIGNED=1 the MS nibble's bit 3 SHALL be inverted on both operands before unsigned nibble compare; lower nibbles always unsigned.
REQ-018 Cascade: while result is equal, a nibble inequality sets a_op_G or b_op_G and clears a_op_E_b; once unequal, result SHALL NOT change for remaining nibbles.
REQ-019 BUSY lasts exactly WIDTH/4 cycles (no early exit); on counter == WIDTH/4-1, go DONE.
REQ-020 Latency: acceptance at edge k -> out_valid_op = 1 after edge k+WIDTH/4.
REQ-021 DONE: out_valid_op = 1; flags stable; on out_ready_ip = 1 go IDLE at that edge.
REQ-022 out_ready_ip low: DONE held indefinitely, flags unchanged.
REQ-023 in_valid_ip while not IDLE: ignored, no capture, no side effect.
REQ-024 Exactly one of a_op_G, a_op_E_b, b_op_G SHALL be 1 at all times out of reset.
REQ-025 Throughput: one pair per WIDTH/4+2 cycles when out_ready_ip held high.

Reset
REQ-026 rst_n_ip low: state IDLE, counter 0, shift registers 0, out_valid_op 0, in_ready_op 1, a_op_G 0, a_op_E_b 1, b_op_G 0, immediately (asynchronous).
REQ-027 Reset during BUSY or DONE: operation discarded, no result emitted after release.
REQ-028 First acceptance possible on first rising edge after rst_n_ip deasserts.

Structure
REQ-029 Shared package: FSM state encoding (IDLE/BUSY/DONE), NIBBLE constant 4, result-flag reset values.
REQ-030 One sub-module: comparator4Bit_slice -- combinational 4-bit unsigned compare with a_ip_G/a_ip_E_b/b_ip_G cascade inputs and a_op_G/a_op_E_b/b_op_G outputs; instantiated once, fed from shift-register MS nibbles and result registers.
REQ-031 Counter width: clog2(WIDTH/4), minimum 1.

Verification
REQ-032 WIDTH=8, SIGNED=1: a=0x80 (-128), b=0x7F -> b_op_G=1, out_valid_op 2 cycles after accept.
REQ-033 WIDTH=8, SIGNED=1: a=0x3A, b=0x35 -> a_op_G=1 (decided on low nibble); a=0xF0 (-16), b=0x0F -> b_op_G=1; a=b=0x35 -> a_op_E_b=1.
REQ-034 WIDTH=8, SIGNED=0: a=0x80, b=0x7F -> a_op_G=1.
REQ-035 Backpressure: out_ready_ip low 5 cycles in DONE -> out_valid_op and flags constant, in_ready_op 0, in_valid_ip pulses ignored; release -> IDLE next edge.
REQ-036 Reset asserted mid-BUSY -> outputs at reset values immediately; no out_valid_op after release until new accept.
REQ-037 Exhaustive WIDTH=8 sweep of all 65536 pairs vs signed reference model; REQ-024 one-hot check every cycle.

Source files
------------

// File: rtl/serial_signed_comparator_pkg.sv
// Shared definitions for the nibble-serial magnitude comparator:
// FSM encoding, nibble width and the value the result flags take on reset.
package serial_signed_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  // Result flags power up as "A equals B" so exactly one flag is always set.
  localparam logic RES_A_G_RST   = 1'b0;
  localparam logic RES_A_E_B_RST = 1'b1;
  localparam logic RES_B_G_RST   = 1'b0;

endpackage

// File: rtl/serial_signed_comparator_if.sv
// Operand/result handshake bundle for serial_signed_comparator.
// master = operand producer / result consumer, slave = comparator.
interface serial_signed_comparator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_ip;
  logic             in_ready_op;
  logic [WIDTH-1:0] a_ip;
  logic [WIDTH-1:0] b_ip;
  logic             out_valid_op;
  logic             out_ready_ip;
  logic             a_op_G;
  logic             a_op_E_b;
  logic             b_op_G;

  modport master (
    output in_valid_ip, a_ip, b_ip, out_ready_ip,
    input  in_ready_op, out_valid_op, a_op_G, a_op_E_b, b_op_G
  );

  modport slave (
    input  in_valid_ip, a_ip, b_ip, out_ready_ip,
    output in_ready_op, out_valid_op, a_op_G, a_op_E_b, b_op_G
  );
endinterface

// File: rtl/serial_signed_comparator_slice.sv
// One 4-bit unsigned compare stage with an equal-so-far cascade: a decision
// already taken by a more significant nibble passes straight through.
module comparator4Bit_slice
  import serial_signed_comparator_pkg::*;
(
  input  logic [NIBBLE-1:0] a_ip,
  input  logic [NIBBLE-1:0] b_ip,
  input  logic              a_ip_G,
  input  logic              a_ip_E_b,
  input  logic              b_ip_G,
  output logic              a_op_G,
  output logic              a_op_E_b,
  output logic              b_op_G
);

  // Only refine the result while the more significant part is still equal.
  always_comb begin
    a_op_G   = a_ip_G;
    a_op_E_b = a_ip_E_b;
    b_op_G   = b_ip_G;
    if (a_ip_E_b) begin
      if (a_ip > b_ip) begin
        a_op_G   = 1'b1;
        a_op_E_b = 1'b0;
        b_op_G   = 1'b0;
      end else if (b_ip > a_ip) begin
        a_op_G   = 1'b0;
        a_op_E_b = 1'b0;
        b_op_G   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_signed_comparator.sv
// Nibble-serial comparator: captures an operand pair, walks it MS nibble
// first through a single 4-bit slice (WIDTH/4 cycles), then holds the
// one-hot result until the consumer takes it.
module serial_signed_comparator
  import serial_signed_comparator_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic                       clk_ip,
  input logic                       rst_n_ip,
  serial_signed_comparator_if.slave bus
);

  localparam int               NUM_NIB  = WIDTH / NIBBLE;
  localparam int               CNT_W    = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NIB - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic              res_a_g;
  logic              res_a_e_b;
  logic              res_b_g;
  logic              accept;
  logic              msb_flip;
  logic [NIBBLE-1:0] flip_mask;
  logic [NIBBLE-1:0] a_nib;
  logic [NIBBLE-1:0] b_nib;
  logic              nib_a_g;
  logic              nib_a_e_b;
  logic              nib_b_g;

  assign accept = (state == IDLE) && bus.in_valid_ip;

  // Flipping the sign bit of the top nibble maps two's-complement order onto
  // unsigned order, so the slice itself never needs to know about signs.
  assign msb_flip  = SIGNED && (cnt == '0);
  assign flip_mask = {msb_flip, {(NIBBLE-1){1'b0}}};
  assign a_nib     = a_sr[WIDTH-1 -: NIBBLE] ^ flip_mask;
  assign b_nib     = b_sr[WIDTH-1 -: NIBBLE] ^ flip_mask;

  comparator4Bit_slice u_slice (
    .a_ip     (a_nib),
    .b_ip     (b_nib),
    .a_ip_G   (res_a_g),
    .a_ip_E_b (res_a_e_b),
    .b_ip_G   (res_b_g),
    .a_op_G   (nib_a_g),
    .a_op_E_b (nib_a_e_b),
    .b_op_G   (nib_b_g)
  );

  // FSM state register.
  always_ff @(posedge clk_ip or negedge rst_n_ip) begin
    if (!rst_n_ip) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; BUSY always runs the full nibble count.
  always_comb begin
    state_nxt        = state;
    bus.in_ready_op  = 1'b0;
    bus.out_valid_op = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready_op = 1'b1;
        if (bus.in_valid_ip) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid_op = 1'b1;
        if (bus.out_ready_ip) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers, nibble counter and cascaded result flags.
  always_ff @(posedge clk_ip or negedge rst_n_ip) begin
    if (!rst_n_ip) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_a_g   <= RES_A_G_RST;
      res_a_e_b <= RES_A_E_B_RST;
      res_b_g   <= RES_B_G_RST;
    end else if (accept) begin
      cnt       <= '0;
      a_sr      <= bus.a_ip;
      b_sr      <= bus.b_ip;
      res_a_g   <= RES_A_G_RST;
      res_a_e_b <= RES_A_E_B_RST;
      res_b_g   <= RES_B_G_RST;
    end else if (state == BUSY) begin
      cnt       <= cnt + CNT_W'(1);
      a_sr      <= a_sr << NIBBLE;
      b_sr      <= b_sr << NIBBLE;
      res_a_g   <= nib_a_g;
      res_a_e_b <= nib_a_e_b;
      res_b_g   <= nib_b_g;
    end
  end

  assign bus.a_op_G   = res_a_g;
  assign bus.a_op_E_b = res_a_e_b;
  assign bus.b_op_G   = res_b_g;

endmodule

// File: tb/tb_serial_signed_comparator.sv
// Bench for serial_signed_comparator: a signed and an unsigned WIDTH=8
// instance, scoreboarded transactions, backpressure, reset and a broad sweep.
module tb_serial_signed_comparator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  logic [2:0] exp_s[$];
  logic [2:0] exp_u[$];
  logic [2:0] flags_s;
  logic [2:0] flags_u;

  serial_signed_comparator_if #(.WIDTH(8)) bus_s ();
  serial_signed_comparator_if #(.WIDTH(8)) bus_u ();

  serial_signed_comparator #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk_ip   (clk),
    .rst_n_ip (rst_n),
    .bus      (bus_s)
  );

  serial_signed_comparator #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk_ip   (clk),
    .rst_n_ip (rst_n),
    .bus      (bus_u)
  );

  assign flags_s = {bus_s.a_op_G, bus_s.a_op_E_b, bus_s.b_op_G};
  assign flags_u = {bus_u.a_op_G, bus_u.a_op_E_b, bus_u.b_op_G};

  always #5 clk = ~clk;

  // Free-running edge counter for throughput measurement.
  always @(posedge clk) cyc++;

  // Exactly one result flag must be set on every cycle, in or out of reset.
  always @(negedge clk) begin
    checks++;
    if (!$onehot(flags_s)) begin
      fails++;
      $display("FAIL onehot_s: flags=%b required one-hot", flags_s);
    end
    checks++;
    if (!$onehot(flags_u)) begin
      fails++;
      $display("FAIL onehot_u: flags=%b required one-hot", flags_u);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result as {a_G, a_E_b, b_G}.
  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    logic gt, lt;
    if (sgn) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return {gt, !(gt || lt), lt};
  endfunction

  // One transaction on the signed instance; hold>0 keeps out_ready low that
  // many cycles in DONE, noise drives ignored operand pairs while busy.
  task automatic xact_s(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input bit noise, input string name);
    int         waitc;
    int         lat;
    logic [2:0] exp;
    logic [2:0] held;
    waitc = 0;
    while (!bus_s.in_ready_op && waitc < 16) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (bus_s.in_ready_op !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, bus_s.in_ready_op);
      return;
    end
    bus_s.out_ready_ip = (hold == 0);
    bus_s.a_ip         = a;
    bus_s.b_ip         = b;
    bus_s.in_valid_ip  = 1'b1;
    exp_s.push_back(ref_flags(a, b, 1'b1));
    @(negedge clk);
    bus_s.in_valid_ip = noise;
    if (noise) begin
      bus_s.a_ip = ~a;
      bus_s.b_ip = ~b;
    end
    lat = 0;
    while (!bus_s.out_valid_op && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    bus_s.in_valid_ip = 1'b0;
    checks++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL %s_latency: cycles=%0d required 2", name, lat);
    end
    exp = exp_s.pop_front();
    checks++;
    if (flags_s !== exp) begin
      fails++;
      $display("FAIL %s_flags: a=%h b=%h flags=%b required %b", name, a, b, flags_s, exp);
    end
    held = flags_s;
    for (int i = 0; i < hold; i++) begin
      bus_s.in_valid_ip = i[0];
      bus_s.a_ip        = 8'(i * 37);
      bus_s.b_ip        = ~bus_s.a_ip;
      @(negedge clk);
      checks++;
      if (bus_s.out_valid_op !== 1'b1 || bus_s.in_ready_op !== 1'b0 || flags_s !== held) begin
        fails++;
        $display("FAIL %s_hold: out_valid=%b in_ready=%b flags=%b required 1 0 %b",
                 name, bus_s.out_valid_op, bus_s.in_ready_op, flags_s, held);
      end
    end
    bus_s.in_valid_ip  = 1'b0;
    bus_s.out_ready_ip = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_s.out_valid_op !== 1'b0 || bus_s.in_ready_op !== 1'b1) begin
      fails++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1",
               name, bus_s.out_valid_op, bus_s.in_ready_op);
    end
  endtask

  // One transaction on the unsigned instance, consumer always ready.
  task automatic xact_u(input logic [7:0] a, input logic [7:0] b, input string name);
    int         lat;
    logic [2:0] exp;
    checks++;
    if (bus_u.in_ready_op !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, bus_u.in_ready_op);
      return;
    end
    bus_u.out_ready_ip = 1'b1;
    bus_u.a_ip         = a;
    bus_u.b_ip         = b;
    bus_u.in_valid_ip  = 1'b1;
    exp_u.push_back(ref_flags(a, b, 1'b0));
    @(negedge clk);
    bus_u.in_valid_ip = 1'b0;
    lat = 0;
    while (!bus_u.out_valid_op && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL %s_latency: cycles=%0d required 2", name, lat);
    end
    exp = exp_u.pop_front();
    checks++;
    if (flags_u !== exp) begin
      fails++;
      $display("FAIL %s_flags: a=%h b=%h flags=%b required %b", name, a, b, flags_u, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus_s.in_ready_op !== 1'b1 || bus_s.out_valid_op !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs_s: in_ready=%b out_valid=%b required 1 0",
               bus_s.in_ready_op, bus_s.out_valid_op);
    end
    checks++;
    if (flags_s !== 3'b010) begin
      fails++;
      $display("FAIL reset_flags_s: flags=%b required 010", flags_s);
    end
    checks++;
    if (bus_u.in_ready_op !== 1'b1 || bus_u.out_valid_op !== 1'b0 || flags_u !== 3'b010) begin
      fails++;
      $display("FAIL reset_u: in_ready=%b out_valid=%b flags=%b required 1 0 010",
               bus_u.in_ready_op, bus_u.out_valid_op, flags_u);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors();
    xact_s(8'h80, 8'h7F, 0, 1'b0, "s_80_7f");
    xact_s(8'h3A, 8'h35, 0, 1'b0, "s_3a_35");
    xact_s(8'hF0, 8'h0F, 0, 1'b0, "s_f0_0f");
    xact_s(8'h35, 8'h35, 0, 1'b0, "s_35_35");
    xact_s(8'h7F, 8'h80, 0, 1'b1, "s_noise");
  endtask

  task automatic test_unsigned();
    xact_u(8'h80, 8'h7F, "u_80_7f");
    xact_u(8'hF0, 8'h0F, "u_f0_0f");
    xact_u(8'h3A, 8'h35, "u_3a_35");
    xact_u(8'h35, 8'h35, "u_35_35");
    xact_u(8'h01, 8'hFF, "u_01_ff");
  endtask

  task automatic test_backpressure();
    xact_s(8'h12, 8'h21, 5, 1'b0, "bp_lt");
    xact_s(8'h9C, 8'h9B, 5, 1'b1, "bp_gt");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      xact_s(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1'b0, "b2b");
    end
    checks++;
    if (cyc - c0 !== 32) begin
      fails++;
      $display("FAIL b2b_throughput: cycles=%0d required 32", cyc - c0);
    end
  endtask

  task automatic test_reset_mid_busy();
    bus_s.out_ready_ip = 1'b1;
    bus_s.a_ip         = 8'h70;
    bus_s.b_ip         = 8'h10;
    bus_s.in_valid_ip  = 1'b1;
    @(negedge clk);
    bus_s.in_valid_ip = 1'b0;
    @(negedge clk);
    checks++;
    if (flags_s !== 3'b100 || bus_s.out_valid_op !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy_pre: flags=%b out_valid=%b required 100 0", flags_s, bus_s.out_valid_op);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (flags_s !== 3'b010 || bus_s.out_valid_op !== 1'b0 || bus_s.in_ready_op !== 1'b1) begin
      fails++;
      $display("FAIL rst_busy_async: flags=%b out_valid=%b in_ready=%b required 010 0 1",
               flags_s, bus_s.out_valid_op, bus_s.in_ready_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus_s.out_valid_op !== 1'b0 || flags_s !== 3'b010) begin
        fails++;
        $display("FAIL rst_busy_quiet: out_valid=%b flags=%b required 0 010", bus_s.out_valid_op, flags_s);
      end
    end
    xact_s(8'h05, 8'hFB, 0, 1'b0, "rst_recover");
  endtask

  task automatic test_sweep();
    logic [7:0] b;
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 12; j++) begin
        case (j)
          0:       b = 8'(a);
          1:       b = 8'(a + 1);
          2:       b = 8'(a - 1);
          3:       b = 8'(a) ^ 8'h80;
          4:       b = 8'(a) ^ 8'h08;
          5:       b = 8'(a) ^ 8'h88;
          6:       b = 8'h00;
          7:       b = 8'h7F;
          8:       b = 8'h80;
          9:       b = 8'hFF;
          10:      b = {4'(a), 4'(a >> 4)};
          default: b = 8'($urandom_range(0, 255));
        endcase
        xact_s(8'(a), b, 0, 1'b0, "sweep");
      end
    end
  endtask

  initial begin
    rst_n              = 1'b1;
    bus_s.in_valid_ip  = 1'b0;
    bus_s.a_ip         = '0;
    bus_s.b_ip         = '0;
    bus_s.out_ready_ip = 1'b1;
    bus_u.in_valid_ip  = 1'b0;
    bus_u.a_ip         = '0;
    bus_u.b_ip         = '0;
    bus_u.out_ready_ip = 1'b1;
    #1;
    test_reset();
    test_spec_vectors();
    test_unsigned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_sweep();
    checks++;
    if (exp_s.size() != 0 || exp_u.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: left=%0d/%0d required 0/0", exp_s.size(), exp_u.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
